// File: rtl/controlo_barreira_if.sv
// Gate controller signal bundle: entry/exit sensors in, arm/motor/space status out.
interface controlo_barreira_if;
  logic       Carro;
  logic       Pedido;
  logic       Passou;
  logic       Saida;
  logic       Obstaculo;
  logic       Barreira;
  logic       Sobe;
  logic       Desce;
  logic [7:0] Lugares;
  logic       Cheio;

  modport master (
    output Carro, Pedido, Passou, Saida, Obstaculo,
    input  Barreira, Sobe, Desce, Lugares, Cheio
  );

  modport slave (
    input  Carro, Pedido, Passou, Saida, Obstaculo,
    output Barreira, Sobe, Desce, Lugares, Cheio
  );
endinterface

// File: rtl/controlo_barreira.sv
// Parking barrier controller: arm sequencing, motor commands and free-space count.
// Outputs are decoded from the next state so they move on the same edge as the FSM.
module controlo_barreira #(
  parameter int T_MOVE   = 100_000_000,
  parameter int T_OPEN   = 500_000_000,
  parameter int CAPACITY = 50
) (
  input  logic              CLK,
  input  logic              Reset_n,
  controlo_barreira_if.slave io
);

  localparam int TMAX = (T_MOVE > T_OPEN) ? T_MOVE : T_OPEN;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] MOVE_LD = CW'(T_MOVE - 1);
  localparam logic [CW-1:0] OPEN_LD = CW'(T_OPEN - 1);
  localparam logic [CW-1:0] T_ONE   = CW'(1);
  localparam logic [7:0]    CAP8    = 8'(CAPACITY);

  localparam logic [1:0] FECHADA  = 2'd0;
  localparam logic [1:0] A_SUBIR  = 2'd1;
  localparam logic [1:0] ABERTA   = 2'd2;
  localparam logic [1:0] A_DESCER = 2'd3;

  logic [1:0]    r_state, w_nstate;
  logic [CW-1:0] r_tempo, w_ntempo;
  logic [7:0]    r_lug, w_nlug;
  logic          r_cheio;
  logic          r_barreira, r_sobe, r_desce;

  // Each edge register holds "input was low last cycle". Clearing it on reset
  // means a level already high when reset releases never looks like an edge.
  logic r_ped_low, r_pas_low, r_sai_low;
  logic w_ped_e, w_pas_e, w_sai_e;
  logic w_pass;

  assign w_ped_e = io.Pedido & r_ped_low;
  assign w_pas_e = io.Passou & r_pas_low;
  assign w_sai_e = io.Saida  & r_sai_low;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ped_low <= 1'b0;
      r_pas_low <= 1'b0;
      r_sai_low <= 1'b0;
    end else begin
      r_ped_low <= ~io.Pedido;
      r_pas_low <= ~io.Passou;
      r_sai_low <= ~io.Saida;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ntempo = r_tempo;
    w_pass   = 1'b0;
    case (r_state)
      FECHADA: begin
        if (w_ped_e && io.Carro && !r_cheio) begin
          w_nstate = A_SUBIR;
          w_ntempo = MOVE_LD;
        end
      end
      A_SUBIR: begin
        if (r_tempo == '0) begin
          w_nstate = ABERTA;
          w_ntempo = OPEN_LD;
        end else begin
          w_ntempo = r_tempo - T_ONE;
        end
      end
      ABERTA: begin
        // A pass coinciding with the timeout is still counted as a pass.
        if (w_pas_e) begin
          w_pass   = 1'b1;
          w_nstate = A_DESCER;
          w_ntempo = MOVE_LD;
        end else if (r_tempo == '0) begin
          w_nstate = A_DESCER;
          w_ntempo = MOVE_LD;
        end else begin
          w_ntempo = r_tempo - T_ONE;
        end
      end
      A_DESCER: begin
        if (io.Obstaculo) begin
          w_nstate = A_SUBIR;
          w_ntempo = MOVE_LD;
        end else if (r_tempo == '0) begin
          w_nstate = FECHADA;
        end else begin
          w_ntempo = r_tempo - T_ONE;
        end
      end
      default: begin
        w_nstate = FECHADA;
        w_ntempo = '0;
      end
    endcase
  end

  // Simultaneous entry and exit cancel; otherwise saturate at 0 and CAPACITY.
  always_comb begin
    w_nlug = r_lug;
    if (w_pass && !w_sai_e) begin
      if (r_lug != 8'd0) w_nlug = r_lug - 8'd1;
    end else if (w_sai_e && !w_pass) begin
      if (r_lug < CAP8) w_nlug = r_lug + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= FECHADA;
      r_tempo    <= '0;
      r_lug      <= CAP8;
      r_cheio    <= 1'b0;
      r_barreira <= 1'b0;
      r_sobe     <= 1'b0;
      r_desce    <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_tempo    <= w_ntempo;
      r_lug      <= w_nlug;
      r_cheio    <= (w_nlug == 8'd0);
      r_barreira <= (w_nstate != FECHADA);
      r_sobe     <= (w_nstate == A_SUBIR);
      r_desce    <= (w_nstate == A_DESCER);
    end
  end

  assign io.Barreira = r_barreira;
  assign io.Sobe     = r_sobe;
  assign io.Desce    = r_desce;
  assign io.Lugares  = r_lug;
  assign io.Cheio    = r_cheio;

endmodule

// File: tb/tb_controlo_barreira.sv
// Directed scenarios plus random traffic against a phase/age reference model.
module tb_controlo_barreira;
  localparam int T_MOVE = 4;
  localparam int T_OPEN = 10;
  localparam int CAP    = 2;

  logic CLK;
  logic Reset_n;
  int   tests = 0;
  int   fails = 0;

  controlo_barreira_if io ();

  controlo_barreira #(.T_MOVE(T_MOVE), .T_OPEN(T_OPEN), .CAPACITY(CAP)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .io(io)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: phase 0 closed, 1 rising, 2 open, 3 lowering; age counts up
  // cycles spent in the current phase.
  int m_phase, m_age, m_lug;
  bit m_ped_ok, m_pas_ok, m_sai_ok;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_lug = CAP;
    m_ped_ok = 0; m_pas_ok = 0; m_sai_ok = 0;
  endtask

  task automatic model_edge();
    bit pe, pa, se, passed;
    int lug;
    pe = io.Pedido && m_ped_ok;
    pa = io.Passou && m_pas_ok;
    se = io.Saida  && m_sai_ok;
    m_ped_ok = !io.Pedido; m_pas_ok = !io.Passou; m_sai_ok = !io.Saida;
    passed = 0;
    case (m_phase)
      0: if (pe && io.Carro && m_lug != 0) begin m_phase = 1; m_age = 0; end
      1: if (m_age == T_MOVE-1) begin m_phase = 2; m_age = 0; end else m_age++;
      2: if (pa) begin passed = 1; m_phase = 3; m_age = 0; end
         else if (m_age == T_OPEN-1) begin m_phase = 3; m_age = 0; end
         else m_age++;
      default: if (io.Obstaculo) begin m_phase = 1; m_age = 0; end
               else if (m_age == T_MOVE-1) begin m_phase = 0; m_age = 0; end
               else m_age++;
    endcase
    lug = m_lug + (se ? 1 : 0) - (passed ? 1 : 0);
    if (lug < 0) lug = 0;
    if (lug > CAP) lug = CAP;
    m_lug = lug;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("barreira", {8'd0, io.Barreira}, {8'd0, m_phase != 0});
    chk("sobe",     {8'd0, io.Sobe},     {8'd0, m_phase == 1});
    chk("desce",    {8'd0, io.Desce},    {8'd0, m_phase == 3});
    chk("lugares",  {1'b0, io.Lugares},  9'(m_lug));
    chk("cheio",    {8'd0, io.Cheio},    {8'd0, m_lug == 0});
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic entry_to_open();
    io.Pedido = 1'b1; step();
    io.Pedido = 1'b0;
    repeat (T_MOVE) step();
  endtask

  task automatic close_arm();
    repeat (T_MOVE) step();
  endtask

  initial begin
    io.Carro = 1'b0; io.Pedido = 1'b0; io.Passou = 1'b0;
    io.Saida = 1'b0; io.Obstaculo = 1'b0;
    Reset_n = 1'b1;
    model_reset();
    #1 Reset_n = 1'b0;
    #11;
    chk("rst_barreira", {8'd0, io.Barreira}, 9'd0);
    chk("rst_sobe",     {8'd0, io.Sobe},     9'd0);
    chk("rst_desce",    {8'd0, io.Desce},    9'd0);
    chk("rst_lugares",  {1'b0, io.Lugares},  9'd2);
    chk("rst_cheio",    {8'd0, io.Cheio},    9'd0);
    #8 Reset_n = 1'b1;
    step(); step();

    // Basic entry: rise 4 cycles, open, pass, fall 4 cycles.
    io.Carro = 1'b1; io.Pedido = 1'b1; step();
    chk("s1_sobe_k", {8'd0, io.Sobe}, 9'd1);
    io.Pedido = 1'b0;
    repeat (3) begin step(); chk("s1_sobe", {8'd0, io.Sobe}, 9'd1); end
    step();
    chk("s1_open_sobe", {8'd0, io.Sobe}, 9'd0);
    chk("s1_open_barr", {8'd0, io.Barreira}, 9'd1);
    io.Passou = 1'b1; step();
    chk("s1_lug", {1'b0, io.Lugares}, 9'd1);
    chk("s1_desce_k", {8'd0, io.Desce}, 9'd1);
    io.Passou = 1'b0;
    repeat (3) begin step(); chk("s1_desce", {8'd0, io.Desce}, 9'd1); end
    step();
    chk("s1_closed", {8'd0, io.Barreira}, 9'd0);

    // Open timeout: exactly T_OPEN cycles open, count unchanged.
    entry_to_open();
    repeat (T_OPEN-1) begin step(); chk("s2_still_open", {8'd0, io.Desce}, 9'd0); end
    step();
    chk("s2_timeout_desce", {8'd0, io.Desce}, 9'd1);
    chk("s2_lug", {1'b0, io.Lugares}, 9'd1);
    close_arm();

    // Fill up, refused request when full, exit frees a space.
    entry_to_open();
    io.Passou = 1'b1; step(); io.Passou = 1'b0;
    chk("s3_lug0", {1'b0, io.Lugares}, 9'd0);
    chk("s3_cheio", {8'd0, io.Cheio}, 9'd1);
    close_arm();
    io.Pedido = 1'b1; step();
    chk("s3_refused", {8'd0, io.Barreira}, 9'd0);
    io.Pedido = 1'b0; step();
    io.Saida = 1'b1; step();
    chk("s3_exit_lug", {1'b0, io.Lugares}, 9'd1);
    chk("s3_exit_cheio", {8'd0, io.Cheio}, 9'd0);
    io.Saida = 1'b0; step();

    // Obstacle on the 2nd cycle of lowering forces a full re-rise.
    entry_to_open();
    io.Passou = 1'b1; step(); io.Passou = 1'b0;
    step();
    io.Obstaculo = 1'b1; step();
    chk("s4_desce_off", {8'd0, io.Desce}, 9'd0);
    chk("s4_sobe_on", {8'd0, io.Sobe}, 9'd1);
    io.Obstaculo = 1'b0;
    repeat (3) begin step(); chk("s4_rerise", {8'd0, io.Sobe}, 9'd1); end
    step();
    chk("s4_open", {8'd0, io.Sobe}, 9'd0);
    repeat (T_OPEN) step();
    close_arm();
    io.Saida = 1'b1; step(); io.Saida = 1'b0; step();
    io.Saida = 1'b1; step(); io.Saida = 1'b0; step();

    // Saturation at capacity and simultaneous pass/exit.
    io.Saida = 1'b1; step();
    chk("s5_sat_cap", {1'b0, io.Lugares}, 9'd2);
    io.Saida = 1'b0; step();
    entry_to_open();
    io.Passou = 1'b1; step(); io.Passou = 1'b0;
    close_arm();
    entry_to_open();
    io.Passou = 1'b1; io.Saida = 1'b1; step();
    chk("s5_pass_exit", {1'b0, io.Lugares}, 9'd1);
    io.Passou = 1'b0; io.Saida = 1'b0;
    close_arm();

    // Asynchronous reset mid-rise, request held high across release.
    io.Pedido = 1'b1; step(); io.Pedido = 1'b0;
    step(); step();
    #2 Reset_n = 1'b0;
    #1;
    chk("s6_rst_sobe", {8'd0, io.Sobe}, 9'd0);
    chk("s6_rst_barr", {8'd0, io.Barreira}, 9'd0);
    chk("s6_rst_lug", {1'b0, io.Lugares}, 9'd2);
    model_reset();
    io.Pedido = 1'b1;
    #2 Reset_n = 1'b1;
    repeat (5) begin step(); chk("s6_held_req", {8'd0, io.Barreira}, 9'd0); end
    io.Pedido = 1'b0; step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      io.Carro     = ($urandom_range(0, 3) != 0);
      io.Pedido    = ($urandom_range(0, 5) == 0);
      io.Passou    = ($urandom_range(0, 5) == 0);
      io.Saida     = ($urandom_range(0, 11) == 0);
      io.Obstaculo = ($urandom_range(0, 9) == 0);
      step();
      chk("excl_sobe_desce", {8'd0, io.Sobe & io.Desce}, 9'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
